// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback packer: collects chain tail bits into words, LSB first.
// A word is emitted when full, or when flush_i is high and a partial word
// is pending; the bit captured on that same edge is included.
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cap_en_i,
  input  logic              tail_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] rb_data_o,
  output logic              rb_valid_o
);

  localparam int RB_CNT_W = cnt_width(WORD_W);

  logic [WORD_W-1:0]   rb_sr_q, rb_sr_d;
  logic [RB_CNT_W-1:0] rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0]   rb_data_q;
  logic                rb_valid_q;
  logic                emit;

  // Merge the captured tail bit and decide whether a word leaves this edge.
  always_comb begin
    rb_sr_d  = rb_sr_q | (WORD_W'(tail_i & cap_en_i) << rb_cnt_q);
    rb_cnt_d = rb_cnt_q + RB_CNT_W'(cap_en_i);
    emit     = (rb_cnt_d == RB_CNT_W'(WORD_W)) || (flush_i && (rb_cnt_d != '0));
  end

  // Capture register, word output and one-cycle valid pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rb_sr_q    <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= emit;
      if (emit) begin
        rb_data_q <= rb_sr_d;
        rb_sr_q   <= '0;
        rb_cnt_q  <= '0;
      end else begin
        rb_sr_q  <= rb_sr_d;
        rb_cnt_q <= rb_cnt_d;
      end
    end
  end

  assign rb_data_o  = rb_data_q;
  assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain driver: serializes host words onto ccff_head with a
// registered clock enable for the external ICG, and repacks the old chain
// contents from ccff_tail into readback words.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | accepting words and shifting bits until bits_left reaches 0
// FLUSH | last tail bit captured; partial readback word emitted
// DONE  | done pulse; busy drops on leaving
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int SR_W  = cnt_width(WORD_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  req_left_q, req_left_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [SR_W-1:0]   sr_cnt_q, sr_cnt_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              accept, shift_en, flush;

  // req_left counts bits not yet covered by accepted words, so the host is
  // refused once the chain length has been requested.
  assign bs_ready = (state_q != IDLE) && !hold_full_q && (req_left_q != '0);
  assign accept   = bs_valid && bs_ready;
  assign shift_en = (state_q == SHIFT) && (sr_cnt_q != '0) && (bits_left_q != '0);
  assign flush    = (state_q == SHIFT) && (bits_left_q == '0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (bits_left_q == '0) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath next values: load setup, host transfer, shift and refill.
  always_comb begin
    bits_left_d = bits_left_q;
    req_left_d  = req_left_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sr_d        = sr_q;
    sr_cnt_d    = sr_cnt_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;

    if (state_q == IDLE && start) begin
      bits_left_d = CNT_W'(CHAIN_LEN);
      req_left_d  = CNT_W'(CHAIN_LEN);
      hold_d      = '0;
      hold_full_d = 1'b0;
      sr_d        = '0;
      sr_cnt_d    = '0;
    end

    if (shift_en) begin
      head_d      = sr_q[0];
      clk_en_d    = 1'b1;
      sr_d        = sr_q >> 1;
      sr_cnt_d    = sr_cnt_q - SR_W'(1);
      bits_left_d = bits_left_q - CNT_W'(1);
    end

    // Refill on the edge the shift register runs dry, keeping 1 bit/cycle.
    if ((state_q == SHIFT) && hold_full_q &&
        ((sr_cnt_q == '0) || (shift_en && (sr_cnt_q == SR_W'(1))))) begin
      sr_d        = hold_q;
      sr_cnt_d    = SR_W'(WORD_W);
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_d      = bs_data;
      hold_full_d = 1'b1;
      if (int'(req_left_q) > WORD_W) req_left_d = req_left_q - CNT_W'(WORD_W);
      else                           req_left_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      bits_left_q <= '0;
      req_left_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      bits_left_q <= bits_left_d;
      req_left_q  <= req_left_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sr_q        <= sr_d;
      sr_cnt_q    <= sr_cnt_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;

  ccff_rb_packer #(.WORD_W(WORD_W)) u_rb_packer (
    .clk_i      (prog_clk),
    .rst_i      (pReset),
    .cap_en_i   (clk_en_q),
    .tail_i     (ccff_tail),
    .flush_i    (flush),
    .rb_data_o  (rb_data),
    .rb_valid_o (rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 4-bit and a 20-bit chain modelled as shift
// registers clocked by ccff_clk_en; readback words checked via scoreboards.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-bit chain instance
  logic       a_start, a_busy, a_done, a_bs_valid, a_bs_ready, a_head, a_clk_en, a_tail, a_rb_valid;
  logic [7:0] a_bs_data, a_rb_data;
  logic       a_pre_en;
  logic [3:0] a_pre_val, a_chain;

  // 20-bit chain instance
  logic        b_start, b_busy, b_done, b_bs_valid, b_bs_ready, b_head, b_clk_en, b_tail, b_rb_valid;
  logic [7:0]  b_bs_data, b_rb_data;
  logic        b_pre_en;
  logic [19:0] b_pre_val, b_chain;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(4)) u_dut4 (
    .prog_clk(clk), .pReset(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .bs_data(a_bs_data), .bs_valid(a_bs_valid), .bs_ready(a_bs_ready),
    .ccff_head(a_head), .ccff_clk_en(a_clk_en), .ccff_tail(a_tail),
    .rb_data(a_rb_data), .rb_valid(a_rb_valid));

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) u_dut20 (
    .prog_clk(clk), .pReset(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .bs_data(b_bs_data), .bs_valid(b_bs_valid), .bs_ready(b_bs_ready),
    .ccff_head(b_head), .ccff_clk_en(b_clk_en), .ccff_tail(b_tail),
    .rb_data(b_rb_data), .rb_valid(b_rb_valid));

  // Chain models: head enters the top FF, tail is FF 0.
  always @(posedge clk) begin
    if (a_pre_en)      a_chain <= a_pre_val;
    else if (a_clk_en) a_chain <= {a_head, a_chain[3:1]};
  end
  always @(posedge clk) begin
    if (b_pre_en)      b_chain <= b_pre_val;
    else if (b_clk_en) b_chain <= {b_head, b_chain[19:1]};
  end
  assign a_tail = a_chain[0];
  assign b_tail = b_chain[0];

  typedef struct {
    logic [3:0] pre;
    logic [7:0] word;
    logic [3:0] exp_chain;
    logic [7:0] exp_rb;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_en = 0, a_dn = 0, b_en = 0, b_dn = 0;
  int b_first = -1, b_last = -1;
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // One clock; all monitoring happens at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (a_clk_en) a_en++;
    if (a_done)   a_dn++;
    if (a_rb_valid) begin
      if (a_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_rb_unexpected actual=0x%0h required=no word", a_rb_data);
      end else chk("a_rb_data", 32'(a_rb_data), 32'(a_q.pop_front()));
    end
    if (b_clk_en) begin
      b_en++;
      if (b_first < 0) b_first = cyc;
      b_last = cyc;
    end
    if (b_done) b_dn++;
    if (b_rb_valid) begin
      if (b_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_rb_unexpected actual=0x%0h required=no word", b_rb_data);
      end else chk("b_rb_data", 32'(b_rb_data), 32'(b_q.pop_front()));
    end
  endtask

  task automatic pre_a(input logic [3:0] v);
    a_pre_val = v; a_pre_en = 1'b1; tick(); a_pre_en = 1'b0;
  endtask

  task automatic pre_b(input logic [19:0] v);
    b_pre_val = v; b_pre_en = 1'b1; tick(); b_pre_en = 1'b0;
  endtask

  // Full load on the 4-bit chain; optionally keep bs_valid high and pulse start mid-load.
  task automatic load_a(input vec_t v, input bit do_pre, input bit hold_valid, input bit restart);
    int en0, dn0, rdy_after;
    bit hs;
    if (do_pre) pre_a(v.pre);
    a_q.push_back(v.exp_rb);
    en0 = a_en; dn0 = a_dn; rdy_after = 0; hs = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_bs_data = v.word; a_bs_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (a_dn != dn0) break;
      if (hs && a_bs_ready) rdy_after++;
      if (!hs && a_bs_ready) hs = 1'b1;
      a_start = restart && (a_en == en0 + 2);
      tick();
      if (hs && !hold_valid) a_bs_valid = 1'b0;
    end
    a_bs_valid = 1'b0; a_start = 1'b0;
    repeat (4) tick();
    chk("a_chain", 32'(a_chain), 32'(v.exp_chain));
    chk("a_clk_en_cycles", 32'(a_en - en0), 32'd4);
    chk("a_done_pulses", 32'(a_dn - dn0), 32'd1);
    chk("a_ready_after_word", 32'(rdy_after), 32'd0);
    chk("a_busy_end", 32'(a_busy), 32'd0);
    chk("a_rb_pending", 32'(a_q.size()), 32'd0);
  endtask

  task automatic send_b(input logic [7:0] w, output int hs_cyc);
    b_bs_data = w; b_bs_valid = 1'b1; hs_cyc = -1;
    for (int n = 0; n < 100; n++) begin
      if (b_bs_ready) begin hs_cyc = cyc; tick(); break; end
      tick();
    end
    b_bs_valid = 1'b0;
    if (hs_cyc < 0) begin
      checks++; failures++;
      $display("FAIL b_handshake actual=timeout required=bs_ready word=0x%0h", w);
    end
  endtask

  // 20-bit load of words 0x12,0x34,0x05; gap>0 inserts an underrun after word 1 drains.
  task automatic load_b(input logic [19:0] pre, input int gap, output logic [19:0] chain_out);
    int en0, dn0, hs0, hs1, hs2;
    pre_b(pre);
    b_q.push_back(pre[7:0]);
    b_q.push_back(pre[15:8]);
    b_q.push_back({4'b0000, pre[19:16]});
    en0 = b_en; dn0 = b_dn; b_first = -1; b_last = -1;
    b_start = 1'b1; tick(); b_start = 1'b0;
    send_b(8'h12, hs0);
    if (gap > 0) begin
      for (int n = 0; n < 40 && (b_en - en0) < 8; n++) tick();
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("b_gap_clk_en", 32'(b_clk_en), 32'd0);
      end
    end
    send_b(8'h34, hs1);
    send_b(8'h05, hs2);
    for (int n = 0; n < 80 && b_dn == dn0; n++) tick();
    repeat (3) tick();
    chk("b_chain", 32'(b_chain), 32'h53412);
    chk("b_clk_en_cycles", 32'(b_en - en0), 32'd20);
    chk("b_done_pulses", 32'(b_dn - dn0), 32'd1);
    chk("b_rb_pending", 32'(b_q.size()), 32'd0);
    if (gap == 0) begin
      // ready seen at cyc k -> transfer edge k+1 -> first clk_en visible at k+3
      chk("b_first_clk_en_latency", 32'(b_first - hs0), 32'd3);
      chk("b_clk_en_span", 32'(b_last - b_first), 32'd19);
    end
    chain_out = b_chain;
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    logic [19:0] c_nostall, c_stall;
    int en0, dn0;

    vecs[0] = '{4'b0011, 8'hA5, 4'b0101, 8'h03};
    vecs[1] = '{4'b1111, 8'h3C, 4'b1100, 8'h0F};
    vecs[2] = '{4'b1010, 8'hF0, 4'b0000, 8'h0A};
    vecs[3] = '{4'b0000, 8'h0F, 4'b1111, 8'h00};
    vecs[4] = '{4'b0110, 8'h69, 4'b1001, 8'h06};

    a_start = 0; a_bs_valid = 0; a_bs_data = '0; a_pre_en = 0; a_pre_val = '0;
    b_start = 0; b_bs_valid = 0; b_bs_data = '0; b_pre_en = 0; b_pre_val = '0;

    rst = 1'b1;
    a_start = 1'b1;
    repeat (3) tick();
    a_start = 1'b0;
    chk("reset_a_outputs", 32'({a_busy, a_done, a_bs_ready, a_head, a_clk_en, a_rb_valid, a_rb_data}), 32'd0);
    chk("reset_b_outputs", 32'({b_busy, b_done, b_bs_ready, b_head, b_clk_en, b_rb_valid, b_rb_data}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) load_a(vecs[i], 1'b1, 1'b0, 1'b0);

    v = '{4'b0101, 8'h96, 4'b0110, 8'h05};
    load_a(v, 1'b1, 1'b1, 1'b1);

    load_b(20'hABCDE, 0, c_nostall);
    load_b(20'h13579, 5, c_stall);
    chk("b_stall_vs_nostall", 32'(c_stall), 32'(c_nostall));

    // Reset after two shifts: chain keeps the partial shift, nothing is reported.
    pre_a(4'b1001);
    en0 = a_en; dn0 = a_dn;
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_bs_data = 8'hC3; a_bs_valid = 1'b1;
    for (int n = 0; n < 20 && !a_bs_ready; n++) tick();
    tick();
    a_bs_valid = 1'b0;
    for (int n = 0; n < 20 && (a_en - en0) < 2; n++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", 32'({a_busy, a_done, a_bs_ready, a_head, a_clk_en, a_rb_valid, a_rb_data}), 32'd0);
    chk("rst_mid_chain", 32'(a_chain), 32'b1110);
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_mid_no_done", 32'(a_dn - dn0), 32'd0);
    chk("rst_mid_clk_en_cycles", 32'(a_en - en0), 32'd2);
    v = '{4'b0000, 8'h5A, 4'b1010, 8'h0E};
    load_a(v, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
